// File: rtl/led_status_engine.sv
// led_status_engine: front-panel LED controller.
// Drives a BAR_WIDTH-wide mode field (link-down / error / cylon / log2 rate bar),
// N_EVT stretched event flashes, N_STAT blink-gated status LEDs and an alive bit.
// Optional build macro LED_DIM_EN adds brightness_i and a 15-step PWM dimmer.
//
// Mode select (priority, evaluated every cycle):
//   mode         | meaning
//   MODE_LINK_DN | link not ready: whole field follows blink
//   MODE_ERROR   | error: 0101.. pattern XOR blink, swaps each half-period
//   MODE_CYLON   | no hit seen since reset/resync: bouncing one-hot
//   MODE_RATE    | thermometer bar of log2(rate_o)
module led_status_engine #(
   parameter int BAR_WIDTH     = 8,
   parameter int N_EVT         = 4,
   parameter int N_STAT        = 4,
   parameter int INC_WIDTH     = 11,
   parameter int COUNT_WIDTH   = 32,
   parameter int WINDOW_CYCLES = 40079000,
   parameter int FLASH_LEN     = 4000000,
   parameter int BLINK_DIV     = 21,
   parameter int CYLON_DIV     = 22
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              link_ok_i,
   input  logic                              err_i,
   input  logic                              resync_i,
   input  logic [N_EVT-1:0]                  evt_i,
   input  logic [N_STAT-1:0]                 stat_i,
   input  logic [INC_WIDTH-1:0]              increment_i,
`ifdef LED_DIM_EN
   input  logic [3:0]                        brightness_i,
`endif
   output logic [COUNT_WIDTH-1:0]            rate_o,
   output logic [BAR_WIDTH+N_EVT+N_STAT:0]   led_out
);

   localparam int LED_W = BAR_WIDTH + N_EVT + N_STAT + 1;
   localparam int FW    = $clog2(FLASH_LEN + 1);
   localparam int WW    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int PW    = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

   localparam logic [1:0] MODE_RATE    = 2'd0;
   localparam logic [1:0] MODE_CYLON   = 2'd1;
   localparam logic [1:0] MODE_ERROR   = 2'd2;
   localparam logic [1:0] MODE_LINK_DN = 2'd3;

   localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
   localparam logic [FW-1:0] FLASH_LD = FW'(FLASH_LEN);

   logic [BLINK_DIV-1:0]   blink_cnt;
   logic                   blink;
   logic [N_EVT-1:0]       flash;
   logic [WW-1:0]          win_cnt;
   logic [COUNT_WIDTH-1:0] acc;
   logic [COUNT_WIDTH:0]   acc_sum;
   logic [COUNT_WIDTH-1:0] acc_sat;
   logic                   first_hit;
   logic [PW-1:0]          cylon_pos;
   logic [BAR_WIDTH-1:0]   cylon_oh;
   logic [BAR_WIDTH-1:0]   bar;
   logic [BAR_WIDTH-1:0]   err_pat;
   logic [BAR_WIDTH-1:0]   field;
   logic [1:0]             mode_sel;
   logic [LED_W-1:0]       led_reg;
   int                     bar_len;

   // Free-running blink divider; blink flips each time the divider passes zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else begin
         blink_cnt <= blink_cnt + BLINK_DIV'(1);
         if (blink_cnt == '0)
            blink <= ~blink;
      end
   end

   // Per-channel flash stretchers; a new event reloads (extends) the flash.
   for (genvar k = 0; k < N_EVT; k++) begin : g_flash
      logic [FW-1:0] cnt;

      // Load on event, otherwise count down to zero and hold.
      always_ff @(posedge clock or posedge reset) begin
         if (reset)
            cnt <= '0;
         else if (evt_i[k])
            cnt <= FLASH_LD;
         else if (cnt != '0)
            cnt <= cnt - FW'(1);
      end

      assign flash[k] = (cnt != '0);
   end

   // Saturating accumulate; increment is zero-extended before the add.
   always_comb begin
      acc_sum = {1'b0, acc} + (COUNT_WIDTH+1)'(increment_i);
      acc_sat = acc_sum[COUNT_WIDTH] ? '1 : acc_sum[COUNT_WIDTH-1:0];
   end

   // Rate window: accumulate hits, publish and clear on the last window cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         win_cnt <= '0;
         acc     <= '0;
         rate_o  <= '0;
      end else if (win_cnt == WIN_LAST) begin
         win_cnt <= '0;
         acc     <= '0;
         rate_o  <= acc_sat;
      end else begin
         win_cnt <= win_cnt + WW'(1);
         acc     <= acc_sat;
      end
   end

   // first_hit latches any nonzero increment; resync wins over a same-cycle hit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         first_hit <= 1'b0;
      else if (resync_i)
         first_hit <= 1'b0;
      else if (increment_i != '0)
         first_hit <= 1'b1;
   end

   if (BAR_WIDTH > 1) begin : g_cylon
      localparam logic [PW-1:0] POS_LAST = PW'(BAR_WIDTH - 1);
      logic [CYLON_DIV-1:0] step_cnt;
      logic                 dir_up;

      // Bouncing position; each endpoint is shown once per pass.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            step_cnt  <= '0;
            cylon_pos <= '0;
            dir_up    <= 1'b1;
         end else begin
            step_cnt <= step_cnt + CYLON_DIV'(1);
            if (&step_cnt) begin
               if (dir_up) begin
                  if (cylon_pos == POS_LAST) begin
                     cylon_pos <= POS_LAST - PW'(1);
                     dir_up    <= 1'b0;
                  end else begin
                     cylon_pos <= cylon_pos + PW'(1);
                  end
               end else begin
                  if (cylon_pos == '0) begin
                     cylon_pos <= PW'(1);
                     dir_up    <= 1'b1;
                  end else begin
                     cylon_pos <= cylon_pos - PW'(1);
                  end
               end
            end
         end
      end
   end else begin : g_no_cylon
      assign cylon_pos = '0;
   end

   // Log2 thermometer bar, cylon one-hot and error pattern.
   always_comb begin
      bar_len = 0;
      for (int i = 0; i < COUNT_WIDTH; i++)
         if (rate_o[i])
            bar_len = i + 1;
      if (bar_len > BAR_WIDTH)
         bar_len = BAR_WIDTH;
      for (int i = 0; i < BAR_WIDTH; i++) begin
         bar[i]      = (i < bar_len);
         cylon_oh[i] = (int'(cylon_pos) == i);
         err_pat[i]  = ((i % 2) == 0) ^ blink;
      end
   end

   // Priority mode select and the field it drives.
   always_comb begin
      if (!link_ok_i)
         mode_sel = MODE_LINK_DN;
      else if (err_i)
         mode_sel = MODE_ERROR;
      else if (!first_hit)
         mode_sel = MODE_CYLON;
      else
         mode_sel = MODE_RATE;

      case (mode_sel)
         MODE_LINK_DN: field = {BAR_WIDTH{blink}};
         MODE_ERROR:   field = err_pat;
         MODE_CYLON:   field = cylon_oh;
         default:      field = bar;
      endcase
   end

   // Registered LED vector: alive, gated status, flashes, mode field.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         led_reg <= '0;
      else
         led_reg <= {1'b1, stat_i & {N_STAT{blink}}, flash, field};
   end

`ifdef LED_DIM_EN
   logic [3:0] pwm_cnt;

   // PWM phase counter, 15 steps so brightness 15 is fully on.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         pwm_cnt <= '0;
      else if (pwm_cnt == 4'd14)
         pwm_cnt <= '0;
      else
         pwm_cnt <= pwm_cnt + 4'd1;
   end

   assign led_out = led_reg & {LED_W{(pwm_cnt < brightness_i)}};
`else
   assign led_out = led_reg;
`endif

endmodule

// File: tb/tb_led_status_engine.sv
// Directed testbench for led_status_engine with small timing parameters.
module tb_led_status_engine;

   logic        clock = 1'b0;
   logic        reset;
   logic        link_ok_i;
   logic        err_i;
   logic        resync_i;
   logic [3:0]  evt_i;
   logic [3:0]  stat_i;
   logic [10:0] increment_i;
   logic [15:0] rate_o;
   logic [16:0] led_out;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int base;

   int          p1_cyc [9] = '{1, 3, 9, 10, 16, 17, 18, 29, 31};
   logic [16:0] p1_exp [9] = '{17'h10001, 17'h1F002, 17'h1F010, 17'h10010, 17'h10080,
                               17'h10040, 17'h1F040, 17'h10001, 17'h10002};

   led_status_engine #(
      .BAR_WIDTH(8), .N_EVT(4), .N_STAT(4), .INC_WIDTH(11), .COUNT_WIDTH(16),
      .WINDOW_CYCLES(100), .FLASH_LEN(5), .BLINK_DIV(3), .CYLON_DIV(1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .link_ok_i(link_ok_i),
      .err_i(err_i),
      .resync_i(resync_i),
      .evt_i(evt_i),
      .stat_i(stat_i),
      .increment_i(increment_i),
`ifdef LED_DIM_EN
      .brightness_i(4'hF),
`endif
      .rate_o(rate_o),
      .led_out(led_out)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target)
         step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      link_ok_i   = 1'b1;
      err_i       = 1'b0;
      resync_i    = 1'b0;
      evt_i       = 4'h0;
      stat_i      = 4'hF;
      increment_i = '0;
      #2;
      check_val("rst_led", 32'(led_out), 32'h0);
      check_val("rst_rate", 32'(rate_o), 32'h0);
      #20;
      reset = 1'b0;
      cyc   = 0;

      // Idle: alive bit, blinking status, cylon bounce.
      for (int i = 0; i < 9; i++) begin
         run_to(p1_cyc[i]);
         check_val($sformatf("idle_c%0d", p1_cyc[i]), 32'(led_out), 32'(p1_exp[i]));
      end

      // Event flash on channel 2 with a retrigger.
      base = cyc;
      for (int t = 0; t <= 22; t++) begin
         run_to(base + t);
         if (t >= 11)
            check_val($sformatf("flash_t%0d", t), 32'(led_out[10]), 32'((t >= 12) && (t <= 20)));
         evt_i = ((t == 10) || (t == 14)) ? 4'b0100 : 4'b0000;
      end

      // Rate window with 10 x 3 hits inside window 2.
      run_to(110); increment_i = 11'd3;
      run_to(111); check_val("still_cylon", 32'(led_out[7:0]), 32'h02);
      run_to(112); check_val("rate_mode", 32'(led_out[7:0]), 32'h00);
      run_to(120); increment_i = '0;
      run_to(199); check_val("rate_pre", 32'(rate_o), 32'd0);
      run_to(200); check_val("rate_30", 32'(rate_o), 32'd30);
                   check_val("bar_lag", 32'(led_out[7:0]), 32'h00);
      run_to(201); check_val("bar_30", 32'(led_out[7:0]), 32'h1F);
      run_to(300); check_val("rate_empty", 32'(rate_o), 32'd0);
                   check_val("bar_hold", 32'(led_out[7:0]), 32'h1F);
                   increment_i = 11'd2047;
      run_to(301); check_val("bar_empty", 32'(led_out[7:0]), 32'h00);
      run_to(400); check_val("rate_sat", 32'(rate_o), 32'hFFFF);
                   increment_i = '0;
      run_to(401); check_val("bar_sat", 32'(led_out[7:0]), 32'hFF);

      // Link down beats error; then error pattern; then back to rate bar.
      run_to(410); link_ok_i = 1'b0; err_i = 1'b1;
      run_to(411); check_val("linkdn_lo", 32'(led_out[7:0]), 32'h00);
      run_to(418); check_val("linkdn_hi", 32'(led_out[7:0]), 32'hFF);
                   check_val("stat_on", 32'(led_out[15:12]), 32'hF);
      run_to(420); link_ok_i = 1'b1;
      run_to(421); check_val("err_aa", 32'(led_out[7:0]), 32'hAA);
      run_to(426); check_val("err_55", 32'(led_out[7:0]), 32'h55);
      run_to(434); check_val("err_aa2", 32'(led_out[7:0]), 32'hAA);
      run_to(440); err_i = 1'b0;
      run_to(441); check_val("rate_back", 32'(led_out[7:0]), 32'hFF);

      // Resync together with a hit: resync wins, cylon returns.
      run_to(450); resync_i = 1'b1; increment_i = 11'd5;
      run_to(451); resync_i = 1'b0; increment_i = '0;
      run_to(452); check_val("resync_cyl", 32'(led_out[7:0]), 32'h02);
      run_to(460); check_val("resync_hold", 32'(led_out[7:0]), 32'h20);
      run_to(500); check_val("rate_5", 32'(rate_o), 32'd5);
                   increment_i = 11'd1;
      run_to(510); increment_i = '0;

      // Asynchronous reset mid-window.
      run_to(520);
      #2 reset = 1'b1;
      #1;
      check_val("arst_led", 32'(led_out), 32'h0);
      check_val("arst_rate", 32'(rate_o), 32'h0);
      #2 reset = 1'b0;
      cyc = 0;
      run_to(1);   check_val("post_rst", 32'(led_out), 32'h10001);
      run_to(100); check_val("partial_gone", 32'(rate_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/led_status_engine.md
Name: led_status_engine

Overview:
- Parametrised front-panel LED controller; successor to the fixed 16-LED status block.
- Drives a BAR_WIDTH-wide rate/mode field plus N_EVT event-flash LEDs and N_STAT blink-gated status LEDs.
- Includes a windowed, saturating log2 rate meter and a priority mode FSM (link-down / error / cylon / rate).
- Sits in the control block, fed by TTC, GBT and cluster-count signals.

Parameters:
- BAR_WIDTH, 8, width of the rate/mode LED field.
- N_EVT, 4, number of event-flash channels.
- N_STAT, 4, number of status LEDs.
- INC_WIDTH, 11, width of increment_i.
- COUNT_WIDTH, 32, width of the rate accumulator and rate_o.
- WINDOW_CYCLES, 40079000, clock cycles per rate window.
- FLASH_LEN, 4000000, stretch length of an event flash in cycles.
- BLINK_DIV, 21, blink half-period = 2^BLINK_DIV cycles.
- CYLON_DIV, 22, cylon step period = 2^CYLON_DIV cycles.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- link_ok_i  in  1  GBT link ready and valid.
- err_i  in  1  error condition (e.g. MMCM unlocked).
- resync_i  in  1  TTC resync pulse.
- evt_i  in  N_EVT  event strobes (L1A, BC0, resync, GBT request, ...).
- stat_i  in  N_STAT  level status inputs.
- increment_i  in  INC_WIDTH  per-cycle hit count.
- rate_o  out  COUNT_WIDTH  hits counted in the last complete window.
- led_out  out  BAR_WIDTH+N_EVT+N_STAT+1  registered LED vector.

Behaviour:
- All registers are cleared asynchronously on reset:
  - led_out=0, rate_o=0.
  - Accumulator, window, blink, cylon, flash and PWM counters = 0.
  - blink=0, first_hit=0.
  - Cylon position=0, direction=up.
- LED layout, MSB to LSB:
  - [top] constant 1 (alive).
  - Next N_STAT bits: stat_i[k] & blink.
  - Next N_EVT bits: flash[k].
  - Low BAR_WIDTH bits: mode field.
- Blink: free-running BLINK_DIV-bit counter; blink toggles on the cycle the counter equals 0. Period = 2^(BLINK_DIV+1) cycles.
- Flash channel k:
  - evt_i[k]=1 loads the counter with FLASH_LEN; otherwise the counter decrements to 0 and holds.
  - flash[k] = (counter != 0).
  - An event while the counter is nonzero reloads it (retrigger extends the flash).
  - Latency: evt at cycle n, led bit high at n+2, low at n+2+FLASH_LEN for an isolated pulse.
- Rate meter:
  - Window counter runs 0..WINDOW_CYCLES-1, then wraps.
  - Each cycle acc <= sat(acc + increment_i), saturating at 2^COUNT_WIDTH-1 (no wrap).
  - On the last window cycle: rate_o <= sat(acc + increment_i) and acc <= 0.
  - Reset mid-window discards the partial count.
- Log bar:
  - rate_o=0 gives 0 LEDs lit.
  - Otherwise L = min(BAR_WIDTH, msb_index(rate_o)+1) LEDs lit as a thermometer from bit 0.
- first_hit:
  - Set the cycle after any nonzero increment_i.
  - Cleared by resync_i; resync takes priority when both occur in the same cycle.
  - Not cleared by rate windows.
- Cylon:
  - One-hot position, steps every 2^CYLON_DIV cycles.
  - Bounces with endpoints shown once per pass: 0,1,…,W-1,W-2,…,1,0,1,…
  - BAR_WIDTH=1: position fixed at 0.
- Mode FSM, re-evaluated every cycle, priority order:
  - LINK_DOWN (!link_ok_i): field = all bits = blink.
  - ERROR (err_i): field = alternating 0101… pattern, XORed with all bits = blink, so it swaps each half-period.
  - CYLON (!first_hit): field = cylon one-hot.
  - RATE: field = log bar.
- The cylon position keeps running in every state.
- led_out is registered: mode change at cycle n appears at n+1.

Optional Feature:
- Macro LED_DIM_EN.
- When defined:
  - Adds input port brightness_i [3:0].
  - A 4-bit PWM counter cycles 0..14.
  - Every led_out bit is ANDed with (pwm_cnt < brightness_i): 0 = all off, 15 = full on, 8 = 8/15 duty.
  - The gating is applied to the registered output; latency is unchanged.
- When undefined: no port, no PWM logic; LEDs are at full duty.

Test Plan (BAR_WIDTH=8, N_EVT=4, N_STAT=4, FLASH_LEN=5, WINDOW_CYCLES=100, BLINK_DIV=3, CYLON_DIV=1):
- Reset released, link_ok=1, err=0, increment=0:
  - led_out[16]=1, stat bits toggle every 8 cycles with stat_i=4'hF.
  - Cylon walks 0x01→0x80→0x40…→0x01, 2 cycles per step.
- evt_i[2] pulsed at cycle 10 → led_out[10] high cycles 12–16. A second pulse at cycle 14 → high through cycle 20.
- increment_i=3 for 10 cycles inside one window:
  - Mode leaves CYLON 2 cycles after the first hit.
  - rate_o=30 at window end; bar=0x1F.
  - Next empty window: rate_o=0, bar=0x00.
- increment_i=2047 every cycle with COUNT_WIDTH=16 → rate_o saturates at 65535; bar=0xFF.
- link_ok=0 with err=1 → field all-blink, not alternating. Then link_ok=1 → field 0x55/0xAA swapping every 8 cycles. Then err=0 → rate bar resumes.
- resync_i and nonzero increment in the same cycle → first_hit=0, mode CYLON. Assert reset mid-window → led_out=0 and rate_o=0 immediately (asynchronous).
